// File: rtl/rv32i_single_cycle_core.sv
// rtl/rv32i_single_cycle_core.sv - single-cycle RV32I core (ROM fetch, RAM load/store, one instruction per clock)
// Define RV32M_MUL_EN to add the MUL instruction (OP, funct7=0000001, funct3=000).
module rv32i_single_cycle_core #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [SIZE-1:0]       idata,
  output logic [ADDR_WIDTH-1:0] iaddr,
  output logic [ADDR_WIDTH-1:0] daddr,
  input  logic [SIZE-1:0]       ddata_r,
  output logic [SIZE-1:0]       ddata_w,
  output logic                  d_rw
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [SIZE-1:0] pc, pc_next, pc_plus4;
  logic [SIZE-1:0] regs [32];
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [SIZE-1:0] rs1_val, rs2_val;
  logic [SIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [SIZE-1:0] alu_b, alu_res, mul_res, wb_data;
  logic            alu_alt, is_mul, op_legal, branch_taken, wb_en;

  assign opcode = idata[6:0];
  assign rd     = idata[11:7];
  assign funct3 = idata[14:12];
  assign rs1    = idata[19:15];
  assign rs2    = idata[24:20];
  assign funct7 = idata[31:25];

  assign imm_i = {{20{idata[31]}}, idata[31:20]};
  assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
  assign imm_b = {{20{idata[31]}}, idata[7], idata[30:25], idata[11:8], 1'b0};
  assign imm_u = {idata[31:12], 12'b0};
  assign imm_j = {{12{idata[31]}}, idata[19:12], idata[20], idata[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

`ifdef RV32M_MUL_EN
  assign is_mul  = (opcode == OPC_OP) && (funct7 == 7'b0000001) && (funct3 == 3'b000);
  assign mul_res = rs1_val * rs2_val;
`else
  assign is_mul  = 1'b0;
  assign mul_res = '0;
`endif

  assign op_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                    is_mul;

  // Bit 30 selects SUB/SRA for OP and SRAI for OP-IMM; ADDI must never see it.
  assign alu_alt = ((opcode == OPC_OP) || ((opcode == OPC_OP_IMM) && (funct3 == 3'b101))) && idata[30];
  assign alu_b   = (opcode == OPC_OP) ? rs2_val : ((opcode == OPC_STORE) ? imm_s : imm_i);

  always_comb begin
    alu_res = rs1_val + alu_b;
    if ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) begin
      case (funct3)
        3'b000:  alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
        3'b001:  alu_res = rs1_val << alu_b[4:0];
        3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
        3'b011:  alu_res = {31'b0, rs1_val < alu_b};
        3'b100:  alu_res = rs1_val ^ alu_b;
        3'b101: begin
          if (alu_alt) alu_res = $signed(rs1_val) >>> alu_b[4:0];
          else         alu_res = rs1_val >> alu_b[4:0];
        end
        3'b110:  alu_res = rs1_val | alu_b;
        default: alu_res = rs1_val & alu_b;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_taken = (rs1_val <  rs2_val);
      3'b111:  branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    wb_en   = 1'b0;
    wb_data = alu_res;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = pc + imm_j; end
      OPC_JALR:   begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = {alu_res[SIZE-1:1], 1'b0}; end
      OPC_BRANCH: if (branch_taken) pc_next = pc + imm_b;
      OPC_LOAD:   begin wb_en = 1'b1; wb_data = ddata_r; end
      OPC_OP_IMM: wb_en = 1'b1;
      OPC_OP:     begin wb_en = op_legal; wb_data = is_mul ? mul_res : alu_res; end
      default:    ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wb_en && (rd != 5'd0)) regs[rd] <= wb_data;
    end
  end

  assign iaddr   = pc[ADDR_WIDTH+1:2];
  assign daddr   = alu_res[ADDR_WIDTH+1:2];
  assign ddata_w = rs2_val;
  assign d_rw    = RESET_N && (opcode == OPC_STORE);

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb/tb_rv32i_single_cycle_core.sv - lockstep check of rv32i_single_cycle_core against an instruction-level model
module tb_rv32i_single_cycle_core;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [31:0]   idata, ddata_r, ddata_w;
  logic [AW-1:0] iaddr, daddr;
  logic          d_rw;

  logic [31:0] rom     [WORDS];
  logic [31:0] dut_ram [WORDS];
  logic [31:0] ref_ram [WORDS];
  logic [31:0] rx [32];
  logic [31:0] rpc;

  int vectors = 0, miscompares = 0;
  int stray_stores = 0, lo_word = 0, hi_word = WORDS - 1;
  int emit_ptr;

  rv32i_single_cycle_core #(.ADDR_WIDTH(AW), .SIZE(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .idata(idata), .iaddr(iaddr),
    .daddr(daddr), .ddata_r(ddata_r), .ddata_w(ddata_w), .d_rw(d_rw)
  );

  always #5 CLK = ~CLK;
  assign idata   = rom[iaddr];
  assign ddata_r = dut_ram[daddr];

  always @(posedge CLK) begin
    if (d_rw) begin
      dut_ram[daddr] <= ddata_w;
      if (int'(daddr) < lo_word || int'(daddr) > hi_word) stray_stores <= stray_stores + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2, r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] i_type(input logic [31:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [31:0] imm, input logic [4:0] r2, r1);
    return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_type(input logic [31:0] imm, input logic [4:0] r2, r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_type(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a, b, input logic alt);
    logic [4:0] s;
    s = b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << s;
      3'd2: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return (a >> s) | ((alt && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Compare the cycle's visible outputs with the model, retire one instruction in the model, advance a clock.
  task automatic tick();
    logic [31:0] ins, a, b, res, nxt, ea, ii, is, ib, ij;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr, st;
    ins = rom[rpc[AW+1:2]];
    a = rx[ins[19:15]]; b = rx[ins[24:20]];
    f3 = ins[14:12]; f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = rpc + 4; wr = 0; st = 0; res = 0;
    check("iaddr", {22'b0, iaddr}, {22'b0, rpc[AW+1:2]});
    check("ddata_w", ddata_w, b);
    case (ins[6:0])
      7'h37: begin wr = 1; res = {ins[31:12], 12'b0}; end
      7'h17: begin wr = 1; res = rpc + {ins[31:12], 12'b0}; end
      7'h6f: begin wr = 1; res = rpc + 4; nxt = rpc + ij; end
      7'h67: begin wr = 1; res = rpc + 4; nxt = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: if (a == b) nxt = rpc + ib;
          3'd1: if (a != b) nxt = rpc + ib;
          3'd4: if ($signed(a) <  $signed(b)) nxt = rpc + ib;
          3'd5: if ($signed(a) >= $signed(b)) nxt = rpc + ib;
          3'd6: if (a <  b) nxt = rpc + ib;
          3'd7: if (a >= b) nxt = rpc + ib;
          default: ;
        endcase
      end
      7'h03: begin
        ea = a + ii; wr = 1; res = ref_ram[ea[AW+1:2]];
        check("load_daddr", {22'b0, daddr}, {22'b0, ea[AW+1:2]});
      end
      7'h23: begin
        ea = a + is; st = 1; ref_ram[ea[AW+1:2]] = b;
        check("store_daddr", {22'b0, daddr}, {22'b0, ea[AW+1:2]});
      end
      7'h13: begin wr = 1; res = alu(f3, a, ii, (f3 == 3'd5) && ins[30]); end
      7'h33: begin
        if (f7 == 7'h00) begin wr = 1; res = alu(f3, a, b, 1'b0); end
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin wr = 1; res = alu(f3, a, b, 1'b1); end
`ifdef RV32M_MUL_EN
        else if (f7 == 7'h01 && f3 == 3'd0) begin wr = 1; res = a * b; end
`endif
      end
      default: ;
    endcase
    check("d_rw", {31'b0, d_rw}, {31'b0, st});
    if (wr && ins[11:7] != 5'd0) rx[ins[11:7]] = res;
    rpc = nxt;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    check("d_rw_in_reset", {31'b0, d_rw}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("iaddr_after_reset", {22'b0, iaddr}, 32'd0);
    RESET_N = 1'b1;
    rpc = 0;
    for (int i = 0; i < 32; i++) rx[i] = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < WORDS; i++) rom[i] = 32'h0000_0013;
    emit_ptr = 0;
  endtask
  task automatic emit(input logic [31:0] ins);
    rom[emit_ptr] = ins;
    emit_ptr++;
  endtask
  task automatic fill_ram(input logic [31:0] v, input bit rnd);
    for (int i = 0; i < WORDS; i++) begin
      dut_ram[i] = rnd ? $urandom : v;
      ref_ram[i] = dut_ram[i];
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] imm;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    int k;
    imm = $urandom; rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); f3 = 3'($urandom);
    k = $urandom_range(0, 15);
    case (k)
      0:  return {imm[31:12], rd, 7'h37};
      1:  return {imm[31:12], rd, 7'h17};
      2:  return j_type(imm, rd);
      3:  return i_type(imm, r1, 3'd0, rd, 7'h67);
      4:  return b_type(imm, r2, r1, (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3);
      5:  return i_type(imm, r1, 3'd2, rd, 7'h03);
      6:  return s_type(imm, r2, r1);
      7, 8, 13, 14: begin
        if (f3 == 3'd1) imm[11:5] = 7'b0;
        if (f3 == 3'd5) imm[11:5] = {1'b0, imm[10], 5'b0};
        return i_type(imm, r1, f3, rd, 7'h13);
      end
      9, 10: return r_type(7'h00, r2, r1, f3, rd, 7'h33);
      11: return r_type(7'h20, r2, r1, imm[0] ? 3'd0 : 3'd5, rd, 7'h33);
      12: return r_type(7'h01, r2, r1, imm[1] ? 3'd0 : f3, rd, 7'h33);
      default: begin
        case (imm[2:0])
          3'd0:    return 32'h0000_007F;
          3'd1:    return 32'h0000_01FF;
          3'd2:    return 32'h0000_000F;
          3'd3:    return 32'h0000_0073;
          default: return {imm[31:7], 7'h0B};
        endcase
      end
    endcase
  endfunction

  initial begin
    logic [31:0] vals [10];
    logic [31:0] t;
    logic [31:0] mul_exp;
    int base;

    // ALU ops and x0 immutability; results stored to words 0..4
    clear_rom(); fill_ram(32'hDEAD_BEEF, 0);
    emit(i_type(-5, 0, 0, 1, 7'h13));
    emit(i_type(3, 0, 0, 2, 7'h13));
    emit(r_type(7'h00, 2, 1, 3'd2, 3, 7'h33));
    emit(r_type(7'h00, 2, 1, 3'd3, 4, 7'h33));
    emit(i_type(32'h401, 1, 3'd5, 5, 7'h13));
    emit(r_type(7'h20, 1, 2, 3'd0, 6, 7'h33));
    emit(i_type(7, 0, 0, 0, 7'h13));
    emit(s_type(0, 3, 0)); emit(s_type(4, 4, 0)); emit(s_type(8, 5, 0));
    emit(s_type(12, 6, 0)); emit(s_type(16, 0, 0));
    emit(j_type(0, 0));
    do_reset();
    run(16);
    check("slt", dut_ram[0], 32'd1);
    check("sltu", dut_ram[1], 32'd0);
    check("srai", dut_ram[2], 32'hFFFF_FFFD);
    check("sub", dut_ram[3], 32'd8);
    check("x0", dut_ram[4], 32'd0);

    // SW/LW round trip, plus reset landing on a store
    clear_rom(); fill_ram(32'hDEAD_BEEF, 0);
    emit(i_type(32'h55, 0, 0, 1, 7'h13));
    emit(s_type(8, 1, 0));
    emit(i_type(8, 0, 3'd2, 2, 7'h03));
    emit(s_type(12, 2, 0));
    emit(j_type(0, 0));
    do_reset();
    tick();
    do_reset();
    check("store_suppressed", dut_ram[2], 32'hDEAD_BEEF);
    tick();
    check("sw_d_rw", {31'b0, d_rw}, 32'd1);
    check("sw_daddr", {22'b0, daddr}, 32'd2);
    check("sw_ddata_w", ddata_w, 32'h55);
    tick(); tick();
    check("lw_x2", ddata_w, 32'h55);
    run(3);
    check("lw_stored", dut_ram[3], 32'h55);

    // Control flow: JAL, BEQ taken, BNE not taken, JALR return
    clear_rom(); fill_ram(32'hDEAD_BEEF, 0);
    emit(i_type(5, 0, 0, 2, 7'h13));
    emit(j_type(12, 1));
    emit(s_type(0, 1, 0));
    emit(j_type(28, 0));
    emit(b_type(8, 2, 2, 3'd0));
    emit(i_type(1, 0, 0, 3, 7'h13));
    emit(b_type(8, 2, 2, 3'd1));
    emit(i_type(0, 1, 3'd0, 0, 7'h67));
    emit(32'h0000_0013); emit(32'h0000_0013);
    emit(s_type(4, 3, 0));
    emit(j_type(0, 0));
    do_reset();
    tick(); tick();
    check("jal_target", {22'b0, iaddr}, 32'd4);
    tick();
    check("beq_taken", {22'b0, iaddr}, 32'd6);
    tick();
    check("bne_fallthru", {22'b0, iaddr}, 32'd7);
    tick();
    check("jalr_return", {22'b0, iaddr}, 32'd2);
    check("jal_link", ddata_w, 32'd8);
    run(5);
    check("link_stored", dut_ram[0], 32'd8);
    check("beq_skipped", dut_ram[1], 32'd0);

    // MUL (or NOP when the feature is absent) and illegal opcodes
    clear_rom(); fill_ram(32'hDEAD_BEEF, 0);
    emit(i_type(7, 0, 0, 1, 7'h13));
    emit(i_type(-3, 0, 0, 2, 7'h13));
    emit(i_type(32'h123, 0, 0, 3, 7'h13));
    emit(r_type(7'h01, 2, 1, 3'd0, 3, 7'h33));
    emit(s_type(0, 3, 0));
    emit(32'h0000_007F);
    emit(32'h0000_01FF);
    emit(s_type(4, 3, 0));
    emit(j_type(0, 0));
`ifdef RV32M_MUL_EN
    mul_exp = 32'hFFFF_FFEB;
`else
    mul_exp = 32'h0000_0123;
`endif
    do_reset();
    run(5);
    check("illegal_pc_in", {22'b0, iaddr}, 32'd5);
    tick();
    check("illegal_pc_next", {22'b0, iaddr}, 32'd6);
    tick();
    check("illegal_rd_pc", {22'b0, iaddr}, 32'd7);
    run(2);
    check("mul", dut_ram[0], mul_exp);
    check("illegal_no_wr", dut_ram[1], mul_exp);

    // Bubble sort of 10 signed words at word 64
    clear_rom(); fill_ram(32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      vals[i] = $urandom;
      dut_ram[64 + i] = vals[i];
      ref_ram[64 + i] = vals[i];
    end
    for (int i = 1; i < 10; i++)
      for (int j = i; j > 0 && $signed(vals[j]) < $signed(vals[j-1]); j--) begin
        t = vals[j]; vals[j] = vals[j-1]; vals[j-1] = t;
      end
    emit(i_type(256, 0, 0, 10, 7'h13));
    emit(i_type(9, 0, 0, 11, 7'h13));
    emit(i_type(0, 10, 0, 13, 7'h13));
    emit(i_type(0, 11, 0, 14, 7'h13));
    emit(i_type(0, 13, 3'd2, 5, 7'h03));
    emit(i_type(4, 13, 3'd2, 6, 7'h03));
    emit(b_type(12, 5, 6, 3'd5));
    emit(s_type(0, 6, 13));
    emit(s_type(4, 5, 13));
    emit(i_type(4, 13, 0, 13, 7'h13));
    emit(i_type(-1, 14, 0, 14, 7'h13));
    emit(b_type(-28, 0, 14, 3'd1));
    emit(i_type(-1, 11, 0, 11, 7'h13));
    emit(b_type(-44, 0, 11, 3'd1));
    emit(j_type(0, 0));
    lo_word = 64; hi_word = 73;
    do_reset();
    base = stray_stores;
    run(500);
    for (int i = 0; i < 10; i++) check($sformatf("sorted[%0d]", i), dut_ram[64 + i], vals[i]);
    check("stray_stores", stray_stores - base, 32'd0);
    lo_word = 0; hi_word = WORDS - 1;

    // Random programs filling the whole ROM, checked every cycle
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < WORDS; i++) rom[i] = rand_ins();
      fill_ram(32'h0, 1);
      do_reset();
      run(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
